// File: rtl/fp_mul64_result_queue.sv
// Issue/result queue for the pipelined FP64 multiplier: credit-gated issue, a valid/tag
// shadow pipeline running alongside the multiplier, and a result FIFO toward the consumer.
module fp_mul64_result_queue #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 8,
    parameter int TAGW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [63:0]            req_a,
    input  logic [63:0]            req_b,
    input  logic [TAGW-1:0]        req_tag,
    output logic [63:0]            mul_a,
    output logic [63:0]            mul_b,
    input  logic [63:0]            mul_o,
    input  logic [3:0]             mul_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [63:0]            rsp_data,
    output logic [3:0]             rsp_flags,
    output logic [TAGW-1:0]        rsp_tag,
    output logic [$clog2(DEPTH):0] credits_used
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // The issue cycle is shadow stage 1, so LATENCY-1 registers follow it and
    // vld_pipe[STAGES] is the stage that lines up with mul_o.
    localparam int STAGES = LATENCY - 2;

    typedef struct packed {
        logic [63:0]     data;
        logic [3:0]      flags;
        logic [TAGW-1:0] tag;
    } rsp_t;

    logic                      issue, pop, wr_en, empty, full;
    logic [PW-1:0]             wr_ptr, rd_ptr, credits_q;
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][TAGW-1:0] tag_pipe;
    rsp_t                      mem [DEPTH];
    rsp_t                      head;

    assign mul_a = req_a;
    assign mul_b = req_b;

    // Ready depends only on registered credits, flush and reset, never on pop.
    assign req_ready = rst_n & ~flush & (credits_q < PW'(DEPTH));
    assign issue     = req_valid & req_ready;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rsp_valid = ~empty;
    assign pop       = rsp_valid & rsp_ready;
    assign wr_en     = vld_pipe[STAGES] & ~flush;

    assign head         = mem[rd_ptr[AW-1:0]];
    assign rsp_data     = head.data;
    assign rsp_flags    = head.flags;
    assign rsp_tag      = head.tag;
    assign credits_used = credits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_pipe[0] <= req_tag;
        for (int k = 1; k <= STAGES; k++) tag_pipe[k] <= tag_pipe[k-1];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= '{data: mul_o, flags: mul_flags, tag: tag_pipe[STAGES]};
    end

    // Captures move entries from in-flight into the FIFO, so they leave the credit count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            credits_q <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            credits_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({issue, pop})
                2'b10:   credits_q <= credits_q + PW'(1);
                2'b01:   credits_q <= credits_q - PW'(1);
                default: ;
            endcase
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> !full);
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credits_q <= PW'(DEPTH));
    a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
        credits_q == PW'($countones(vld_pipe)) + (wr_ptr - rd_ptr));
endmodule
